// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, pairs in-order imem responses with their
// PCs and queues them for decode; redirects flush the queue and drop stale responses.
module fetch_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic            if_misaligned
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            mis;
    } entry_t;

    logic [XLEN-1:0] pc;
    logic            stalled;

    logic [XLEN-1:0] pcf_mem [BUF_DEPTH];
    logic [PW-1:0]   pcf_wr;
    logic [PW-1:0]   pcf_rd;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop_cnt;

    entry_t          q_mem [BUF_DEPTH];
    logic [PW-1:0]   q_wr;
    logic [PW-1:0]   q_rd;
    logic [CW-1:0]   q_cnt;

    logic            pc_mis;
    logic            pop;
    logic [CW-1:0]   occ;
    logic            credit;
    logic            issue;
    logic            rsp_ok;
    logic            rsp_keep;
    logic            mis_push;
    logic            push;
    entry_t          push_entry;
    entry_t          head;

    assign pc_mis = |pc[1:0];
    assign pop    = (q_cnt != '0) && if_ready && !redirect_valid;

    // Counting the entry leaving to decode this cycle keeps one fetch per
    // cycle at unit latency; the grant still only drops on acceptance.
    assign occ    = inflight + q_cnt - CW'(pop);
    assign credit = occ < CW'(BUF_DEPTH);

    assign imem_req_valid = !rst && !redirect_valid && !pc_mis && credit;
    assign imem_req_addr  = pc;
    assign issue          = imem_req_valid && imem_req_ready;

    assign rsp_ok   = imem_rsp_valid && (inflight != '0);
    assign rsp_keep = rsp_ok && (drop_cnt == '0) && !redirect_valid;

    // A misaligned PC bypasses imem once older fetches have drained.
    assign mis_push = !redirect_valid && pc_mis && !stalled
                      && (inflight == '0) && credit;
    assign push     = rsp_keep || mis_push;

    always_comb begin
        push_entry = '0;
        if (rsp_keep) begin
            push_entry.pc    = pcf_mem[pcf_rd];
            push_entry.instr = imem_rsp_data;
            push_entry.mis   = 1'b0;
        end else begin
            push_entry.pc    = pc;
            push_entry.instr = NOP;
            push_entry.mis   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            stalled  <= 1'b0;
            pcf_wr   <= '0;
            pcf_rd   <= '0;
            inflight <= '0;
            drop_cnt <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
            q_cnt    <= '0;
        end else begin
            if (issue)
                pcf_wr <= pcf_wr + PW'(1);
            if (rsp_ok)
                pcf_rd <= pcf_rd + PW'(1);
            inflight <= inflight + CW'(issue) - CW'(rsp_ok);

            if (redirect_valid)
                drop_cnt <= inflight - CW'(rsp_ok);
            else if (rsp_ok && (drop_cnt != '0))
                drop_cnt <= drop_cnt - CW'(1);

            if (redirect_valid)
                pc <= redirect_pc;
            else if (issue)
                pc <= pc + XLEN'(4);

            if (redirect_valid)
                stalled <= 1'b0;
            else if (mis_push)
                stalled <= 1'b1;

            if (redirect_valid) begin
                q_rd  <= q_wr;
                q_cnt <= '0;
            end else begin
                if (push)
                    q_wr <= q_wr + PW'(1);
                if (pop)
                    q_rd <= q_rd + PW'(1);
                q_cnt <= q_cnt + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue)
            pcf_mem[pcf_wr] <= pc;
        if (push)
            q_mem[q_wr] <= push_entry;
    end

    assign head          = q_mem[q_rd];
    assign if_valid      = q_cnt != '0;
    assign if_pc         = if_valid ? head.pc : '0;
    assign if_instr      = if_valid ? head.instr : '0;
    assign if_misaligned = if_valid && head.mis;

`ifndef SYNTHESIS
    rsp_has_request: assert property (
        @(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (inflight != '0)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed redirect/stall/wrap/reset scenarios
// with an in-order imem model of configurable latency.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_misaligned;

    fetch_unit #(
        .XLEN(32),
        .RESET_PC(32'h0),
        .BUF_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .if_valid(if_valid),
        .if_ready(if_ready),
        .if_pc(if_pc),
        .if_instr(if_instr),
        .if_misaligned(if_misaligned)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    exp_t  exp_q[$];
    pend_t pend[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pops = 0;
    int last_pop_cyc = 0;
    int acc_cnt = 0;
    int rsp_cnt = 0;
    int k_lat = 1;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // imem: accepts whenever ready, answers in order after k_lat cycles
    initial begin
        pend_t p;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back('{imem_req_addr, cyc + k_lat});
                acc_cnt++;
            end
            @(posedge clk);
            #1;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                p = pend.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = dat(p.addr);
                rsp_cnt++;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'h0;
            end
        end
    end

    // monitor: every decode handshake is checked against the scoreboard
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && if_valid && if_ready && !redirect_valid) begin
            checks++;
            pops++;
            last_pop_cyc = cyc;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL if_out unexpected pc %h instr %h mis %b",
                         if_pc, if_instr, if_misaligned);
            end else begin
                e = exp_q.pop_front();
                if (if_pc !== e.pc || if_instr !== e.instr
                    || if_misaligned !== e.mis) begin
                    errors++;
                    $display("FAIL if_out got pc %h instr %h mis %b required pc %h instr %h mis %b",
                             if_pc, if_instr, if_misaligned,
                             e.pc, e.instr, e.mis);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, req);
        end
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        logic [31:0] a;
        a = base;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{a, dat(a), 1'b0});
            a = a + 32'd4;
        end
    endtask

    task automatic wait_pops(input int n, input string tag);
        int t;
        t = 0;
        while (pops < n && t < 300) begin
            @(posedge clk);
            t++;
        end
        checks++;
        if (pops < n) begin
            errors++;
            $display("FAIL %s pops %0d required %0d", tag, pops, n);
        end
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        exp_q.delete();
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        int c0;
        int t_first;
        int t_last;
        int base;
        int a0;
        int cnt;

        rst            = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;
        repeat (3) tick();
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_if_valid", 64'(if_valid), 64'd0);
        chk("rst_if_pc", 64'(if_pc), 64'd0);
        chk("rst_if_instr", 64'(if_instr), 64'd0);
        chk("rst_if_mis", 64'(if_misaligned), 64'd0);

        // sequential stream, one per cycle
        if_ready = 1'b1;
        push_seq(32'h0, 16);
        base = pops;
        rst  = 1'b0;
        c0   = cyc;
        wait_pops(base + 1, "t1_first");
        t_first = last_pop_cyc;
        wait_pops(base + 16, "t1_all");
        t_last = last_pop_cyc;
        #1 if_ready = 1'b0;
        chk("t1_latency", 64'(t_first), 64'(c0 + 2));
        chk("t1_rate", 64'(t_last - t_first), 64'd15);

        // decode stalled: fetch fills the queue and stops
        redirect(32'h200);
        a0 = acc_cnt;
        repeat (10) tick();
        chk("t2_req_count", 64'(acc_cnt - a0), 64'd2);
        @(negedge clk);
        chk("t2_req_held", 64'(imem_req_valid), 64'd0);
        tick();
        push_seq(32'h200, 8);
        base = pops;
        if_ready = 1'b1;
        wait_pops(base + 8, "t2_resume");
        #1 if_ready = 1'b0;

        // redirect with two requests outstanding at latency 3
        k_lat = 3;
        redirect(32'h80);
        tick();
        tick();
        chk("t3_in_flight", 64'(acc_cnt - rsp_cnt), 64'd2);
        redirect(32'h100);
        push_seq(32'h100, 4);
        base = pops;
        if_ready = 1'b1;
        wait_pops(base + 4, "t3_stream");
        #1;

        // redirect colliding with a response and a decode handshake
        k_lat = 1;
        redirect(32'h400);
        push_seq(32'h400, 3);
        base = pops;
        wait_pops(base + 3, "t4_pre");
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        exp_q.delete();
        @(negedge clk);
        chk("t4_rsp_in_r", 64'(imem_rsp_valid), 64'd1);
        chk("t4_valid_in_r", 64'(if_valid), 64'd1);
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4_flushed", 64'(if_valid), 64'd0);
        tick();
        push_seq(32'h300, 3);
        base = pops;
        wait_pops(base + 3, "t4_post");
        #1 if_ready = 1'b0;

        // misaligned target
        redirect(32'h102);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (imem_req_valid) cnt++;
        end
        chk("t5_no_req", 64'(cnt), 64'd0);
        tick();
        exp_q.push_back('{32'h102, 32'h13, 1'b1});
        base = pops;
        if_ready = 1'b1;
        wait_pops(base + 1, "t5_mis");
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (if_valid || imem_req_valid) cnt++;
        end
        chk("t5_stall", 64'(cnt), 64'd0);
        tick();
        if_ready = 1'b0;

        // PC wrap, then async reset mid-burst
        redirect(32'hFFFF_FFFC);
        @(negedge clk);
        chk("t6_addr_top", 64'(imem_req_addr), 64'hFFFF_FFFC);
        chk("t6_valid_top", 64'(imem_req_valid), 64'd1);
        @(negedge clk);
        chk("t6_addr_wrap", 64'(imem_req_addr), 64'd0);
        chk("t6_valid_wrap", 64'(imem_req_valid), 64'd1);
        tick();
        push_seq(32'hFFFF_FFFC, 5);
        base = pops;
        if_ready = 1'b1;
        wait_pops(base + 4, "t6_wrap");
        #3 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("t6_rst_if_valid", 64'(if_valid), 64'd0);
        chk("t6_rst_if_pc", 64'(if_pc), 64'd0);
        chk("t6_rst_if_instr", 64'(if_instr), 64'd0);
        chk("t6_rst_if_mis", 64'(if_misaligned), 64'd0);
        repeat (3) tick();
        push_seq(32'h0, 3);
        base = pops;
        rst = 1'b0;
        wait_pops(base + 3, "t6_restart");
        #1 if_ready = 1'b0;
        repeat (3) tick();
        chk("end_scoreboard", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
